// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the intersection controller and its sensors/lamps/displays.
// All signals are levels sampled on clk; there is no valid/ready handshake, every value holds until it changes.
interface traffic_light_ctrl_if;
  logic       car_b;
  logic       night;
  logic [2:0] light_a;
  logic [2:0] light_b;
  logic [5:0] count_a;
  logic [5:0] count_b;
  logic [2:0] state_dbg;

  modport master (
    output car_b, night,
    input  light_a, light_b, count_a, count_b, state_dbg
  );

  modport slave (
    input  car_b, night,
    output light_a, light_b, count_a, count_b, state_dbg
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light sequencer: one-second prescaler, A/B green-yellow phases,
// hold on A green until a side-road car appears, and flashing-yellow night mode.
module traffic_light_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int T_AG     = 40,
  parameter int T_AY     = 5,
  parameter int T_BG     = 25,
  parameter int T_BY     = 5
) (
  input logic                 clk,
  input logic                 rst,
  traffic_light_ctrl_if.slave bus
);

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_AG    = 3'd0,
    S_AY    = 3'd1,
    S_BG    = 3'd2,
    S_BY    = 3'd3,
    S_NIGHT = 3'd4
  } state_t;

  state_t        state;
  logic [5:0]    cnt;
  logic [DW-1:0] div_cnt;
  logic          blink;
  logic          tick;

  assign tick = (div_cnt == DW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_AG;
      cnt     <= 6'(T_AG);
      div_cnt <= '0;
      blink   <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      case (state)
        S_NIGHT: begin
          // Leaving night always goes through A yellow so B never gets green abruptly.
          if (!bus.night) begin
            state <= S_AY;
            cnt   <= 6'(T_AY);
          end else if (tick) begin
            blink <= ~blink;
          end
        end
        default: begin
          if (bus.night) begin
            state <= S_NIGHT;
            cnt   <= 6'd0;
            blink <= 1'b0;
          end else if (tick) begin
            if (cnt > 6'd1) begin
              cnt <= cnt - 6'd1;
            end else begin
              case (state)
                S_AG: if (bus.car_b) begin
                  state <= S_AY;
                  cnt   <= 6'(T_AY);
                end
                S_AY: begin
                  state <= S_BG;
                  cnt   <= 6'(T_BG);
                end
                S_BG: begin
                  state <= S_BY;
                  cnt   <= 6'(T_BY);
                end
                S_BY: begin
                  state <= S_AG;
                  cnt   <= 6'(T_AG);
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  // Countdowns include the following phase when a road's lamp stays the same across it.
  always_comb begin
    bus.light_a = 3'b100;
    bus.light_b = 3'b100;
    bus.count_a = 6'd0;
    bus.count_b = 6'd0;
    case (state)
      S_AG: begin
        bus.light_a = 3'b001;
        bus.count_a = cnt;
        bus.count_b = cnt + 6'(T_AY);
      end
      S_AY: begin
        bus.light_a = 3'b010;
        bus.count_a = cnt;
        bus.count_b = cnt;
      end
      S_BG: begin
        bus.light_b = 3'b001;
        bus.count_a = cnt + 6'(T_BY);
        bus.count_b = cnt;
      end
      S_BY: begin
        bus.light_b = 3'b010;
        bus.count_a = cnt;
        bus.count_b = cnt;
      end
      default: begin
        bus.light_a = {1'b0, blink, 1'b0};
        bus.light_b = {1'b0, blink, 1'b0};
      end
    endcase
  end

  assign bus.state_dbg = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Randomized scoreboard bench for traffic_light_ctrl against a phase-table reference model.
module tb_traffic_light_ctrl;
  localparam int TD = 4;
  localparam int AG = 3;
  localparam int AY = 2;
  localparam int BG = 2;
  localparam int BY = 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  traffic_light_ctrl_if bus ();
  traffic_light_ctrl_if bus2 ();

  traffic_light_ctrl #(.TICK_DIV(TD), .T_AG(AG), .T_AY(AY), .T_BG(BG), .T_BY(BY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  traffic_light_ctrl #(.TICK_DIV(2), .T_AG(54), .T_AY(5), .T_BG(1), .T_BY(1)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int         dur[4]        = '{AG, AY, BG, BY};
  logic [2:0] lamp_a_tab[4] = '{3'b001, 3'b010, 3'b100, 3'b100};
  logic [2:0] lamp_b_tab[4] = '{3'b100, 3'b100, 3'b001, 3'b010};

  int   m_e;      // rising edges since reset released
  int   m_phase;  // 0=A green, 1=A yellow, 2=B green, 3=B yellow
  int   m_rem;    // seconds left in the phase
  bit   m_night;
  bit   m_blink;
  logic [17:0] exp_q[$];

  function automatic logic [17:0] model_out();
    logic [2:0] la, lb;
    int ca, cb;
    bit stop_a, stop_b;
    if (m_night) begin
      la = {1'b0, m_blink, 1'b0};
      lb = la;
      ca = 0;
      cb = 0;
    end else begin
      la = lamp_a_tab[m_phase];
      lb = lamp_b_tab[m_phase];
      ca = m_rem;
      cb = m_rem;
      stop_a = 0;
      stop_b = 0;
      for (int k = 1; k < 4; k++) begin
        int q;
        q = (m_phase + k) % 4;
        if (lamp_a_tab[q] != la) stop_a = 1;
        if (!stop_a) ca += dur[q];
        if (lamp_b_tab[q] != lb) stop_b = 1;
        if (!stop_b) cb += dur[q];
      end
    end
    return {la, lb, 6'(ca), 6'(cb)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e = 0; m_phase = 0; m_rem = AG; m_night = 0; m_blink = 0;
      exp_q.delete();
    end else begin
      bit tick;
      m_e++;
      tick = (m_e % TD) == 0;
      if (m_night) begin
        if (!bus.night) begin
          m_night = 0; m_phase = 1; m_rem = AY;
        end else if (tick) begin
          m_blink = ~m_blink;
        end
      end else if (bus.night) begin
        m_night = 1; m_blink = 0;
      end else if (tick) begin
        if (m_rem > 1) m_rem--;
        else if (!(m_phase == 0 && !bus.car_b)) begin
          m_phase = (m_phase + 1) % 4;
          m_rem = dur[m_phase];
        end
      end
    end
    exp_q.push_back(model_out());
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [17:0] got, want;
    got = {bus.light_a, bus.light_b, bus.count_a, bus.count_b};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty t=%0t got=%h", $time, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL outputs t=%0t got la=%b lb=%b ca=%0d cb=%0d want la=%b lb=%b ca=%0d cb=%0d",
                 $time, got[17:15], got[14:12], got[11:6], got[5:0],
                 want[17:15], want[14:12], want[11:6], want[5:0]);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit cond_met(input int kind);
    case (kind)
      0: return !m_night && m_phase == 0 && m_rem == 1 && ((m_e + 2) % TD) == 0;
      default: return !m_night && m_phase != 0 && m_rem == 1 && ((m_e + 1) % TD) == 0;
    endcase
  endfunction

  task automatic wait_model(input int kind);
    int n;
    n = 0;
    while (!cond_met(kind) && n < 200) begin
      step(1);
      n++;
    end
    total++;
    if (!cond_met(kind)) begin
      bad++;
      $display("FAIL wait_timeout kind=%0d got=0 want=1", kind);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad = 0;
    bus.car_b = 1'b1;
    bus.night = 1'b0;
    bus2.car_b = 1'b1;
    bus2.night = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("boundary_reset_ca", int'(bus2.count_a), 54);
    check("boundary_reset_cb", int'(bus2.count_b), 59);
    step(3);
    rst = 1'b0;

    // Second instance: TICK_DIV=2, full cycle is (54+5+1+1)*2 = 122 edges.
    step(2);
    check("boundary_first_tick_cb", int'(bus2.count_b), 58);
    step(120);
    check("boundary_wrap_la", int'(bus2.light_a), 1);
    check("boundary_wrap_cb", int'(bus2.count_b), 59);

    // Hold on A green with no side-road car, then a car two cycles before a tick.
    bus.car_b = 1'b0;
    step(80);
    wait_model(0);
    bus.car_b = 1'b1;
    step(20);

    // Night requested in the cycle whose tick would end a phase.
    wait_model(1);
    bus.night = 1'b1;
    step(1);
    check("night_entry_la", int'(bus.light_a), 0);
    step(20);
    bus.night = 1'b0;
    step(40);

    // Asynchronous reset in the middle of a clock period.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_la", int'(bus.light_a), 1);
    check("async_rst_lb", int'(bus.light_b), 4);
    check("async_rst_ca", int'(bus.count_a), AG);
    check("async_rst_cb", int'(bus.count_b), AG + AY);
    step(2);
    rst = 1'b0;

    // Randomized sensor and night-mode activity.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) bus.car_b = ~bus.car_b;
      if ($urandom_range(0, 59) == 0) bus.night = ~bus.night;
      step(1);
    end
    bus.night = 1'b0;
    step(10);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
